// File: rtl/mem_port_arbiter_if.sv
// Port A bus between the arbiter and the shared memory Control block.
// The arbiter drives address/data/write enable; Control returns read data.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              write_memoryA;
    logic [ADDR_W-1:0] memory_locationA;
    logic [DATA_W-1:0] memory_inputA;
    logic [DATA_W-1:0] data_outA;

    modport master (
        output write_memoryA,
        output memory_locationA,
        output memory_inputA,
        input  data_outA
    );

    modport slave (
        input  write_memoryA,
        input  memory_locationA,
        input  memory_inputA,
        output data_outA
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for memory port A: CPU path (0) vs I/O-DMA path (1).
// Grants, drives the port, waits out read latency and pulses doneN once.
module mem_port_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              last_grant,
    mem_port_arbiter_if.master memA
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t     state;
    state_t     stateNext;
    logic       doGrant;
    logic       grantNext;
    logic       weLatched;
    logic [2:0] waitCnt;

    always_comb begin
        stateNext = state;
        doGrant   = 1'b0;
        grantNext = last_grant;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    doGrant   = 1'b1;
                    stateNext = ACCESS;
                    // On a tie the requester that did not go last wins
                    grantNext = (req0 && req1) ? ~last_grant : req1;
                end
            end
            ACCESS: stateNext = weLatched ? DONE : WAIT;
            WAIT: begin
                if (waitCnt == 3'd1) begin
                    stateNext = DONE;
                end
            end
            DONE: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state                 <= IDLE;
            busy                  <= 1'b0;
            last_grant            <= 1'b1;
            weLatched             <= 1'b0;
            waitCnt               <= 3'd0;
            done0                 <= 1'b0;
            done1                 <= 1'b0;
            rdata0                <= '0;
            rdata1                <= '0;
            memA.write_memoryA    <= 1'b0;
            memA.memory_locationA <= '0;
            memA.memory_inputA    <= '0;
        end else begin
            state              <= stateNext;
            busy               <= (stateNext != IDLE);
            done0              <= 1'b0;
            done1              <= 1'b0;
            memA.write_memoryA <= 1'b0;

            if (doGrant) begin
                last_grant            <= grantNext;
                weLatched             <= grantNext ? we1 : we0;
                memA.write_memoryA    <= grantNext ? we1 : we0;
                memA.memory_locationA <= grantNext ? addr1 : addr0;
                memA.memory_inputA    <= grantNext ? wdata1 : wdata0;
            end

            if (state == ACCESS) begin
                waitCnt <= 3'(READ_LATENCY);
            end

            if (state == WAIT) begin
                waitCnt <= waitCnt - 3'd1;
                if (waitCnt == 3'd1) begin
                    if (last_grant) begin
                        rdata1 <= memA.data_outA;
                    end else begin
                        rdata0 <= memA.data_outA;
                    end
                end
            end

            if (stateNext == DONE) begin
                done0 <= ~last_grant;
                done1 <= last_grant;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single accesses with a scoreboard,
// plus reset-abort, saturation fairness and a READ_LATENCY=3 instance.
module tb_mem_port_arbiter;
    localparam int AW = 24;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A, READ_LATENCY = 1
    logic          req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          done0, done1, busy, lastGrant;
    logic [DW-1:0] rdata0, rdata1;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) memA ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dutA (
        .CLK(clk), .RESET(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .done0(done0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .done1(done1), .rdata1(rdata1),
        .busy(busy), .last_grant(lastGrant),
        .memA(memA)
    );

    // DUT B, READ_LATENCY = 3
    logic          bReq0 = 0, bWe0 = 0, bReq1 = 0, bWe1 = 0;
    logic [AW-1:0] bAddr0 = '0, bAddr1 = '0;
    logic [DW-1:0] bWdata0 = '0, bWdata1 = '0;
    logic          bDone0, bDone1, bBusy, bLastGrant;
    logic [DW-1:0] bRdata0, bRdata1;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) memB ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)) dutB (
        .CLK(clk), .RESET(rst),
        .req0(bReq0), .we0(bWe0), .addr0(bAddr0), .wdata0(bWdata0),
        .done0(bDone0), .rdata0(bRdata0),
        .req1(bReq1), .we1(bWe1), .addr1(bAddr1), .wdata1(bWdata1),
        .done1(bDone1), .rdata1(bRdata1),
        .busy(bBusy), .last_grant(bLastGrant),
        .memA(memB)
    );

    // Memory A: RAM, one-cycle synchronous read
    logic [DW-1:0] memArr [logic [AW-1:0]];
    logic [DW-1:0] pipeA = '0;
    always @(posedge clk) begin
        pipeA <= memArr.exists(memA.memory_locationA) ?
                 memArr[memA.memory_locationA] : '0;
        if (memA.write_memoryA)
            memArr[memA.memory_locationA] = memA.memory_inputA;
    end
    assign memA.data_outA = pipeA;

    // Memory B: ROM, three-cycle read pipeline
    function automatic logic [DW-1:0] romB(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction
    logic [DW-1:0] pipeB [3];
    always @(posedge clk) begin
        pipeB[0] <= romB(memB.memory_locationA);
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end
    assign memB.data_outA = pipeB[2];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          who;
        logic          isWrite;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic          who;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            lat;
    } vec_t;
    vec_t vecs[8];

    int            wrPulses = 0;
    logic [AW-1:0] wrAddr = '0;
    logic [DW-1:0] wrData = '0;
    logic [DW-1:0] expR0 = '0, expR1 = '0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            wrPulses = 0;
            expR0 = '0;
            expR1 = '0;
        end else begin
            if (memA.write_memoryA) begin
                wrPulses++;
                wrAddr = memA.memory_locationA;
                wrData = memA.memory_inputA;
            end
            if (done0 || done1) begin
                chk("single_done", 32'(done0 & done1), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done0=%0b done1=%0b, required none",
                             done0, done1);
                end else begin
                    e = sb.pop_front();
                    chk("done_who", 32'(done1), 32'(e.who));
                    chk("done_cycle", cyc, e.due);
                    chk("last_grant", 32'(lastGrant), 32'(e.who));
                    chk("busy_done", 32'(busy), 1);
                    if (e.isWrite) begin
                        chk("wr_pulses", wrPulses, 1);
                        chk("wr_addr", 32'(wrAddr), 32'(e.addr));
                        chk("wr_data", 32'(wrData), 32'(e.data));
                    end else begin
                        chk("rd_no_write", wrPulses, 0);
                        if (e.who) expR1 = e.data;
                        else expR0 = e.data;
                    end
                    chk("rdata0", 32'(rdata0), 32'(expR0));
                    chk("rdata1", 32'(rdata1), 32'(expR1));
                    wrPulses = 0;
                end
            end
        end
    end

    task automatic access(input vec_t v);
        bit seen = 0;
        @(negedge clk);
        if (v.who) begin
            req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.data;
        end else begin
            req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.data;
        end
        sb.push_back('{v.who, v.we, v.addr, v.data, cyc + v.lat});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (v.who ? done1 : done0) begin
                seen = 1;
                break;
            end
        end
        req0 = 0;
        req1 = 0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout_done%0d: no done in 20 cycles, required one", v.who);
            sb.delete();
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int c0;
        int n;
        logic [AW-1:0] bAddrs [3];

        vecs[0] = '{1'b0, 1'b1, 24'h000010, 16'hBEEF, 2};
        vecs[1] = '{1'b0, 1'b0, 24'h000010, 16'hBEEF, 3};
        vecs[2] = '{1'b1, 1'b0, 24'h00FFFF, 16'h0000, 3};
        vecs[3] = '{1'b1, 1'b1, 24'h00FFFF, 16'h1234, 2};
        vecs[4] = '{1'b1, 1'b0, 24'h00FFFF, 16'h1234, 3};
        vecs[5] = '{1'b0, 1'b1, 24'hFFFFFF, 16'h5555, 2};
        vecs[6] = '{1'b0, 1'b0, 24'hFFFFFF, 16'h5555, 3};
        vecs[7] = '{1'b1, 1'b0, 24'h000010, 16'hBEEF, 3};
        bAddrs[0] = 24'h000300;
        bAddrs[1] = 24'h00C0DE;
        bAddrs[2] = 24'hFFFFFF;

        repeat (2) @(negedge clk);
        chk("rst_wr", 32'(memA.write_memoryA), 0);
        chk("rst_loc", 32'(memA.memory_locationA), 0);
        chk("rst_in", 32'(memA.memory_inputA), 0);
        chk("rst_done0", 32'(done0), 0);
        chk("rst_done1", 32'(done1), 0);
        chk("rst_rdata0", 32'(rdata0), 0);
        chk("rst_rdata1", 32'(rdata1), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_last_grant", 32'(lastGrant), 1);
        rst = 0;

        // Reset during the ACCESS cycle of a write aborts it
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 24'h000ABC; wdata0 = 16'h7777;
        @(negedge clk);
        chk("abort_wr_access", 32'(memA.write_memoryA), 1);
        chk("abort_busy_access", 32'(busy), 1);
        rst = 1;
        req0 = 0;
        @(negedge clk);
        chk("abort_wr", 32'(memA.write_memoryA), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done0", 32'(done0), 0);
        chk("abort_last_grant", 32'(lastGrant), 1);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 8; i++) access(vecs[i]);

        // Saturation: both held high, writes alternate starting with 0
        doReset();
        @(negedge clk);
        c0 = cyc;
        req0 = 1; we0 = 1; addr0 = 24'h000100; wdata0 = 16'h0A0A;
        req1 = 1; we1 = 1; addr1 = 24'h000200; wdata1 = 16'h0B0B;
        for (int k = 0; k < 8; k++)
            sb.push_back('{1'(k % 2), 1'b1,
                           (k % 2 == 1) ? 24'h000200 : 24'h000100,
                           (k % 2 == 1) ? 16'h0B0B : 16'h0A0A,
                           c0 + 2 + 3 * k});
        n = 0;
        for (int i = 0; i < 60 && n < 8; i++) begin
            @(negedge clk);
            if (done0 || done1) n++;
        end
        req0 = 0;
        req1 = 0;
        if (n < 8) begin
            checks++;
            errors++;
            $display("FAIL timeout_saturation: got %0d dones, required 8", n);
            sb.delete();
        end

        // READ_LATENCY=3 instance: sequential reads
        for (int i = 0; i < 3; i++) begin
            bit seen = 0;
            @(negedge clk);
            c0 = cyc;
            bReq0 = 1; bWe0 = 0; bAddr0 = bAddrs[i];
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                if (bDone0) begin
                    seen = 1;
                    break;
                end
            end
            bReq0 = 0;
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL timeout_b_read%0d: no done, required one", i);
            end else begin
                chk("b_done_cycle", cyc, c0 + 5);
                chk("b_rdata0", 32'(bRdata0), 32'(romB(bAddrs[i])));
                chk("b_done1", 32'(bDone1), 0);
                chk("b_rdata1", 32'(bRdata1), 0);
            end
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
